// File: rtl/imu_i2c_arbiter.sv
// Round-robin arbiter that lets two requesters share one I2C register engine,
// with a WAIT timeout that aborts the engine and drains it before responding.
module imu_i2c_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  input  logic [1:0]  req_rw_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_done_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        eng_start_o,
  output logic        eng_rw_o,
  output logic [7:0]  eng_addr_o,
  output logic [7:0]  eng_wdata_o,
  output logic        eng_abort_o,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic [7:0]  eng_rdata_i,
  input  logic        eng_nack_i,
  output logic [7:0]  err_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_DRAIN, S_RESP
  } state_e;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t [1:0] req_cmd;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign req_cmd[i] = {req_rw_i[i], req_addr_i[8*i+7 -: 8], req_wdata_i[8*i+7 -: 8]};
  end

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        win;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  cap_data_q, cap_data_d;
  logic        cap_err_q, cap_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;

  // Both requesting: the one that did not win last time goes next.
  always_comb begin
    case (req_valid_i)
      2'b11:   win = ~last_q;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    err_cnt_d  = err_cnt_q;
    ready_d    = 2'b00;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    done_d     = 2'b00;
    rdata_d    = 8'h00;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!eng_busy_i && (req_valid_i != 2'b00)) begin
          state_d = S_ISSUE;
          gnt_d   = win;
          last_d  = win;
          cmd_d   = req_cmd[win];
        end
      end
      S_ISSUE: begin
        cnt_d   = 20'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 20'd1;
        // A completion in the final timeout cycle still counts as a normal finish.
        if (eng_done_i) begin
          cap_data_d = cmd_q.rw ? eng_rdata_i : 8'h00;
          cap_err_d  = eng_nack_i;
          state_d    = S_RESP;
        end else if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        cap_data_d = 8'h00;
        cap_err_d  = 1'b1;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        if (!eng_busy_i) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (cap_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so each pulse lines up with its state.
    if (state_d == S_ISSUE) begin
      ready_d = gnt_d ? 2'b10 : 2'b01;
      start_d = 1'b1;
    end
    if (state_d == S_ABORT) abort_d = 1'b1;
    if (state_d == S_RESP) begin
      done_d  = gnt_d ? 2'b10 : 2'b01;
      rdata_d = cap_data_d;
      err_d   = cap_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= 20'd0;
      cap_data_q <= 8'h00;
      cap_err_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
      ready_q    <= 2'b00;
      done_q     <= 2'b00;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      err_cnt_q  <= err_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_done_o  = done_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign eng_start_o = start_q;
  assign eng_abort_o = abort_q;
  assign eng_rw_o    = cmd_q.rw;
  assign eng_addr_o  = cmd_q.addr;
  assign eng_wdata_o = cmd_q.wdata;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_imu_i2c_arbiter.sv
// Directed bench for imu_i2c_arbiter: the engine is modelled inline by the
// transaction driver; cycle numbers are counted from the cycle the request is sampled.
module tb_imu_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_rw;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, eng_start, eng_rw, eng_abort;
  logic [7:0]  eng_addr, eng_wdata;
  logic        eng_busy, eng_done, eng_nack;
  logic [7:0]  eng_rdata, err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imu_i2c_arbiter #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_done_o(rsp_done),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .eng_start_o(eng_start), .eng_rw_o(eng_rw),
    .eng_addr_o(eng_addr), .eng_wdata_o(eng_wdata),
    .eng_abort_o(eng_abort), .eng_busy_i(eng_busy),
    .eng_done_i(eng_done), .eng_rdata_i(eng_rdata),
    .eng_nack_i(eng_nack), .err_count_o(err_count)
  );

  logic [39:0] all_outs;
  assign all_outs = {req_ready, rsp_done, rsp_rdata, rsp_err, eng_start, eng_rw,
                     eng_addr, eng_wdata, eng_abort, err_count};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a cycle where the arbiter is idle. The engine completes at WAIT
  // cycle k (k<0: never, stays busy 5 cycles after abort, stray done in DRAIN).
  task automatic do_txn(input logic [1:0] vld, input logic [1:0] rw, input int k,
                        input logic nack, input logic [7:0] rdata, input bit hold,
                        output logic [1:0] o_ready, output logic o_start,
                        output logic o_erw, output logic [7:0] o_eaddr,
                        output logic [7:0] o_ewdata, output int o_done_cyc,
                        output logic [1:0] o_done, output logic [7:0] o_rdata,
                        output logic o_err, output int o_abort_cyc, output int o_abort_n);
    int cyc;
    o_done_cyc = -1; o_abort_cyc = -1; o_abort_n = 0;
    o_done = 2'b00; o_rdata = 8'h00; o_err = 1'b0;
    req_valid = vld; req_rw = rw;
    tick(); cyc = 1;
    o_ready = req_ready; o_start = eng_start; o_erw = eng_rw;
    o_eaddr = eng_addr; o_ewdata = eng_wdata;
    if (!hold) req_valid = 2'b00;
    eng_busy = 1'b1;
    while (cyc < 200 && o_done_cyc < 0) begin
      tick(); cyc++;
      eng_done = 1'b0;
      if (k >= 0 && cyc == 2 + k) begin
        eng_done = 1'b1; eng_rdata = rdata; eng_nack = nack;
      end
      if (k >= 0 && cyc == 3 + k) eng_busy = 1'b0;
      if (eng_abort) begin
        o_abort_n++;
        if (o_abort_cyc < 0) o_abort_cyc = cyc;
      end
      if (k < 0 && o_abort_cyc > 0 && cyc == o_abort_cyc + 2) begin
        eng_done = 1'b1; eng_rdata = rdata; eng_nack = nack;
      end
      if (o_abort_cyc > 0 && cyc == o_abort_cyc + 6) eng_busy = 1'b0;
      if (rsp_done != 2'b00) begin
        o_done_cyc = cyc; o_done = rsp_done; o_rdata = rsp_rdata; o_err = rsp_err;
      end
    end
    eng_done = 1'b0; eng_busy = 1'b0;
    tick();
  endtask

  logic [1:0] t_ready, t_done;
  logic       t_start, t_erw, t_err;
  logic [7:0] t_eaddr, t_ewdata, t_rdata;
  int         t_done_cyc, t_abort_cyc, t_abort_n;

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (all_outs !== 40'd0) begin
      errors++; $display("FAIL reset_hold outs=%h expected 0", all_outs);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (all_outs !== 40'd0) begin
      errors++; $display("FAIL reset_idle outs=%h expected 0", all_outs);
    end
  endtask

  task automatic test_single_write();
    req_addr = 16'h006B; req_wdata = 16'h0000;
    do_txn(2'b01, 2'b00, 3, 1'b0, 8'h77, 1'b0, t_ready, t_start, t_erw, t_eaddr,
           t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
    checks++; if (t_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got=%b exp=01", t_ready); end
    checks++; if (t_start !== 1'b1) begin errors++; $display("FAIL wr_start got=%b exp=1", t_start); end
    checks++; if ({t_erw, t_eaddr, t_ewdata} !== {1'b0, 8'h6B, 8'h00}) begin
      errors++; $display("FAIL wr_cmd got=%b/%h/%h exp=0/6b/00", t_erw, t_eaddr, t_ewdata); end
    checks++; if (t_done_cyc !== 6) begin errors++; $display("FAIL wr_latency got=T%0d exp=T6", t_done_cyc); end
    checks++; if (t_done !== 2'b01) begin errors++; $display("FAIL wr_done got=%b exp=01", t_done); end
    checks++; if ({t_rdata, t_err} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL wr_rsp got=%h/%b exp=00/0", t_rdata, t_err); end
    checks++; if (t_abort_n !== 0) begin errors++; $display("FAIL wr_abort got=%0d exp=0", t_abort_n); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL wr_errcnt got=%h exp=00", err_count); end
    checks++; if (rsp_done !== 2'b00 || rsp_rdata !== 8'h00) begin
      errors++; $display("FAIL wr_rsp_idle got=%b/%h exp=00/00", rsp_done, rsp_rdata); end
  endtask

  task automatic test_read();
    req_addr = 16'h3B00; req_wdata = 16'h5500;
    do_txn(2'b10, 2'b10, 2, 1'b0, 8'hA5, 1'b0, t_ready, t_start, t_erw, t_eaddr,
           t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
    checks++; if (t_ready !== 2'b10) begin errors++; $display("FAIL rd_ready got=%b exp=10", t_ready); end
    checks++; if ({t_erw, t_eaddr} !== {1'b1, 8'h3B}) begin
      errors++; $display("FAIL rd_cmd got=%b/%h exp=1/3b", t_erw, t_eaddr); end
    checks++; if (t_done_cyc !== 5 || t_done !== 2'b10) begin
      errors++; $display("FAIL rd_done got=%b@T%0d exp=10@T5", t_done, t_done_cyc); end
    checks++; if ({t_rdata, t_err} !== {8'hA5, 1'b0}) begin
      errors++; $display("FAIL rd_rsp got=%h/%b exp=a5/0", t_rdata, t_err); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    req_addr = 16'h3311; req_wdata = 16'h4422;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      do_txn(2'b11, 2'b00, 1, 1'b0, 8'h00, 1'b1, t_ready, t_start, t_erw, t_eaddr,
             t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
      checks++; if (t_ready !== exp_g) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, t_ready, exp_g); end
      checks++; if ({t_eaddr, t_ewdata} !== ((i % 2 == 0) ? 16'h1122 : 16'h3344)) begin
        errors++; $display("FAIL rr_cmd%0d got=%h/%h", i, t_eaddr, t_ewdata); end
      checks++; if (t_done !== exp_g || t_done_cyc !== 4) begin
        errors++; $display("FAIL rr_done%0d got=%b@T%0d exp=%b@T4", i, t_done, t_done_cyc, exp_g); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    req_addr = 16'h0042; req_wdata = 16'h0000;
    do_txn(2'b01, 2'b01, -1, 1'b0, 8'hFF, 1'b0, t_ready, t_start, t_erw, t_eaddr,
           t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
    checks++; if (t_abort_cyc !== 18 || t_abort_n !== 1) begin
      errors++; $display("FAIL to_abort got=T%0d x%0d exp=T18 x1", t_abort_cyc, t_abort_n); end
    checks++; if (t_done_cyc !== 25 || t_done !== 2'b01) begin
      errors++; $display("FAIL to_done got=%b@T%0d exp=01@T25", t_done, t_done_cyc); end
    checks++; if ({t_rdata, t_err} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL to_rsp got=%h/%b exp=00/1", t_rdata, t_err); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL to_errcnt got=%h exp=01", err_count); end
  endtask

  task automatic test_boundary();
    req_addr = 16'h0010; req_wdata = 16'h0099;
    do_txn(2'b01, 2'b00, 15, 1'b0, 8'h00, 1'b0, t_ready, t_start, t_erw, t_eaddr,
           t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
    checks++; if (t_abort_n !== 0) begin errors++; $display("FAIL bd_abort got=%0d exp=0", t_abort_n); end
    checks++; if (t_done_cyc !== 18 || t_err !== 1'b0) begin
      errors++; $display("FAIL bd_rsp got=T%0d err=%b exp=T18 err=0", t_done_cyc, t_err); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL bd_errcnt got=%h exp=01", err_count); end
  endtask

  task automatic test_err_saturate();
    int bad = 0;
    req_addr = 16'h0020; req_wdata = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      do_txn(2'b01, 2'b00, 0, 1'b1, 8'h00, 1'b0, t_ready, t_start, t_erw, t_eaddr,
             t_ewdata, t_done_cyc, t_done, t_rdata, t_err, t_abort_cyc, t_abort_n);
      if (t_err !== 1'b1 || t_done_cyc !== 3) bad++;
      if (i == 252) begin
        checks++; if (err_count !== 8'hFE) begin errors++; $display("FAIL sat_fe got=%h exp=fe", err_count); end
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_nack_rsp bad=%0d exp=0", bad); end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_ff got=%h exp=ff", err_count); end
  endtask

  task automatic test_reset_in_wait();
    int leaks = 0;
    req_addr = 16'h00C3; req_wdata = 16'h005A;
    req_valid = 2'b01; req_rw = 2'b00;
    tick();
    req_valid = 2'b00; eng_busy = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_outs !== 40'd0) begin
      errors++; $display("FAIL rst_async outs=%h expected 0", all_outs); end
    tick();
    if (rsp_done !== 2'b00) leaks++;
    rst_n = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req_ready !== 2'b00 || eng_start !== 1'b0 || rsp_done !== 2'b00) leaks++;
    end
    checks++; if (leaks !== 0) begin errors++; $display("FAIL rst_busy_gate leaks=%0d exp=0", leaks); end
    eng_busy = 1'b0;
    tick();
    checks++; if (req_ready !== 2'b01 || eng_addr !== 8'hC3) begin
      errors++; $display("FAIL rst_regrant got=%b/%h exp=01/c3", req_ready, eng_addr); end
    req_valid = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_rw = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_rdata = 8'h00; eng_nack = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_timeout();
    test_boundary();
    test_err_saturate();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
